// File: rtl/uart_apb_fifo.sv
// APB-mapped UART: 8-bit serial channel with TX/RX FIFOs, 16x-oversampling baud
// generator, optional parity and level interrupts.
module uart_apb_fifo #(
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_RESET  = 26
) (
   input  logic        pclk,
   input  logic        prstn,
   input  logic [31:0] paddr,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [31:0] pwdata,
   output logic [31:0] prdata,
   output logic        pready,
   input  logic        uart_rx,
   output logic        uart_tx,
   output logic        uart_ri,
   output logic        uart_ti,
   output logic        ext_uart_en
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   localparam logic [2:0] A_DATA   = 3'd0;
   localparam logic [2:0] A_STATUS = 3'd1;
   localparam logic [2:0] A_CTRL   = 3'd2;
   localparam logic [2:0] A_BAUD   = 3'd3;
   localparam logic [2:0] A_RXTHR  = 3'd4;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   logic       wr_en;
   logic       rd_en;
   logic [2:0] addr;
   logic       unused_bits;

   assign wr_en       = psel & penable & pwrite;
   assign rd_en       = psel & penable & ~pwrite;
   assign addr        = paddr[4:2];
   assign pready      = 1'b1;
   assign unused_bits = ^{paddr[31:5], paddr[1:0], pwdata[31:16]};

   logic [6:0]  ctrl;
   logic [15:0] baud_div;
   logic [7:0]  rxthr;
   logic        tx_en;
   logic        rx_en;
   logic        ti_ie;
   logic        ri_ie;
   logic        par_en;
   logic        par_odd;

   assign tx_en       = ctrl[0];
   assign rx_en       = ctrl[1];
   assign ti_ie       = ctrl[2];
   assign ri_ie       = ctrl[3];
   assign par_en      = ctrl[4];
   assign par_odd     = ctrl[5];
   assign ext_uart_en = ctrl[6];

   always_ff @(posedge pclk or negedge prstn) begin
      if (!prstn) begin
         ctrl     <= '0;
         baud_div <= 16'(DIV_RESET);
         rxthr    <= 8'd1;
      end else if (wr_en) begin
         case (addr)
            A_CTRL:  ctrl     <= pwdata[6:0];
            A_BAUD:  baud_div <= pwdata[15:0];
            A_RXTHR: rxthr    <= pwdata[7:0];
            default: ;
         endcase
      end
   end

   // Baud generator: tick16 fires once every div+1 pclk; a BAUD write restarts the count.
   logic [15:0] baud_cnt;
   logic        tick16;

   assign tick16 = (baud_cnt == 16'd0);

   always_ff @(posedge pclk or negedge prstn) begin
      if (!prstn)
         baud_cnt <= 16'(DIV_RESET);
      else if (wr_en && addr == A_BAUD)
         baud_cnt <= pwdata[15:0];
      else if (tick16)
         baud_cnt <= baud_div;
      else
         baud_cnt <= baud_cnt - 16'd1;
   end

   logic [7:0]  tx_mem [FIFO_DEPTH];
   logic [AW:0] tx_wr;
   logic [AW:0] tx_rd;
   logic [AW:0] tx_level;
   logic        tx_full;
   logic        tx_empty;
   logic        tx_push;
   logic        tx_pop;

   assign tx_level = tx_wr - tx_rd;
   assign tx_empty = (tx_wr == tx_rd);
   assign tx_full  = (tx_wr[AW] != tx_rd[AW]) && (tx_wr[AW-1:0] == tx_rd[AW-1:0]);
   assign tx_push  = wr_en && (addr == A_DATA) && !tx_full;

   logic [7:0]  rx_mem [FIFO_DEPTH];
   logic [AW:0] rx_wr;
   logic [AW:0] rx_rd;
   logic [AW:0] rx_level;
   logic        rx_full;
   logic        rx_empty;
   logic        rx_push_req;
   logic        rx_push;
   logic        rx_pop;
   logic [7:0]  rx_shift;

   assign rx_level = rx_wr - rx_rd;
   assign rx_empty = (rx_wr == rx_rd);
   assign rx_full  = (rx_wr[AW] != rx_rd[AW]) && (rx_wr[AW-1:0] == rx_rd[AW-1:0]);
   assign rx_pop   = rd_en && (addr == A_DATA) && !rx_empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign rx_push  = rx_push_req && (!rx_full || rx_pop);

   always_ff @(posedge pclk) begin
      if (tx_push)
         tx_mem[tx_wr[AW-1:0]] <= pwdata[7:0];
      if (rx_push)
         rx_mem[rx_wr[AW-1:0]] <= rx_shift;
   end

   always_ff @(posedge pclk or negedge prstn) begin
      if (!prstn) begin
         tx_wr <= '0;
         tx_rd <= '0;
         rx_wr <= '0;
         rx_rd <= '0;
      end else begin
         if (tx_push) tx_wr <= tx_wr + PTR_ONE;
         if (tx_pop)  tx_rd <= tx_rd + PTR_ONE;
         if (rx_push) rx_wr <= rx_wr + PTR_ONE;
         if (rx_pop)  rx_rd <= rx_rd + PTR_ONE;
      end
   end

   state_t     tx_state;
   state_t     tx_nx;
   logic [3:0] tx_cnt;
   logic [2:0] tx_idx;
   logic [7:0] tx_byte;
   logic       tx_bit_end;
   logic       tx_line;
   logic       tx_busy;

   assign tx_bit_end = tick16 && (tx_cnt == 4'd15);
   assign tx_busy    = (tx_state != S_IDLE);
   assign uart_tx    = tx_line;

   always_ff @(posedge pclk or negedge prstn) begin
      if (!prstn)
         tx_state <= S_IDLE;
      else
         tx_state <= tx_nx;
   end

   // Pop only sees the registered empty flag, so a push into an empty FIFO is served next cycle.
   always_comb begin
      tx_nx   = tx_state;
      tx_pop  = 1'b0;
      tx_line = 1'b1;
      case (tx_state)
         S_IDLE: begin
            if (tx_en && !tx_empty) begin
               tx_pop = 1'b1;
               tx_nx  = S_START;
            end
         end
         S_START: begin
            tx_line = 1'b0;
            if (tx_bit_end) tx_nx = S_DATA;
         end
         S_DATA: begin
            tx_line = tx_byte[tx_idx];
            if (tx_bit_end && tx_idx == 3'd7) tx_nx = par_en ? S_PARITY : S_STOP;
         end
         S_PARITY: begin
            tx_line = (^tx_byte) ^ par_odd;
            if (tx_bit_end) tx_nx = S_STOP;
         end
         S_STOP: begin
            if (tx_bit_end) tx_nx = S_IDLE;
         end
         default: tx_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge pclk or negedge prstn) begin
      if (!prstn) begin
         tx_cnt <= '0;
         tx_idx <= '0;
      end else if (tx_pop) begin
         tx_cnt <= '0;
         tx_idx <= '0;
      end else if (tick16 && tx_state != S_IDLE) begin
         tx_cnt <= tx_cnt + 4'd1;
         if (tx_state == S_DATA && tx_cnt == 4'd15) tx_idx <= tx_idx + 3'd1;
      end
   end

   always_ff @(posedge pclk) begin
      if (tx_pop) tx_byte <= tx_mem[tx_rd[AW-1:0]];
   end

   logic [1:0] rx_sync;
   logic       rx_s;
   logic       rx_d;
   logic       rx_fall;

   assign rx_s    = rx_sync[1];
   assign rx_fall = rx_d & ~rx_s;

   always_ff @(posedge pclk or negedge prstn) begin
      if (!prstn) begin
         rx_sync <= 2'b11;
         rx_d    <= 1'b1;
      end else begin
         rx_sync <= {rx_sync[0], uart_rx};
         rx_d    <= rx_s;
      end
   end

   state_t     rx_state;
   state_t     rx_nx;
   logic [3:0] rx_cnt;
   logic [2:0] rx_idx;
   logic       rx_sample;
   logic       frame_set;
   logic       parity_set;

   // Counter is zeroed in IDLE, so the 8th tick after the edge lands mid-bit.
   assign rx_sample = tick16 && (rx_cnt == 4'd7);

   always_ff @(posedge pclk or negedge prstn) begin
      if (!prstn)
         rx_state <= S_IDLE;
      else
         rx_state <= rx_nx;
   end

   always_comb begin
      rx_nx       = rx_state;
      rx_push_req = 1'b0;
      frame_set   = 1'b0;
      parity_set  = 1'b0;
      if (!rx_en) begin
         rx_nx = S_IDLE;
      end else begin
         case (rx_state)
            S_IDLE:   if (rx_fall) rx_nx = S_START;
            S_START:  if (rx_sample) rx_nx = rx_s ? S_IDLE : S_DATA;
            S_DATA:   if (rx_sample && rx_idx == 3'd7) rx_nx = par_en ? S_PARITY : S_STOP;
            S_PARITY: begin
               if (rx_sample) begin
                  rx_nx      = S_STOP;
                  parity_set = (rx_s != ((^rx_shift) ^ par_odd));
               end
            end
            S_STOP: begin
               if (rx_sample) begin
                  rx_nx       = S_IDLE;
                  rx_push_req = rx_s;
                  frame_set   = ~rx_s;
               end
            end
            default: rx_nx = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge pclk or negedge prstn) begin
      if (!prstn) begin
         rx_cnt <= '0;
         rx_idx <= '0;
      end else begin
         if (rx_state == S_IDLE)
            rx_cnt <= '0;
         else if (tick16)
            rx_cnt <= rx_cnt + 4'd1;
         if (rx_state != S_DATA)
            rx_idx <= '0;
         else if (rx_sample)
            rx_idx <= rx_idx + 3'd1;
      end
   end

   always_ff @(posedge pclk) begin
      if (rx_state == S_DATA && rx_sample) rx_shift <= {rx_s, rx_shift[7:1]};
   end

   logic       overrun;
   logic       frame_err;
   logic       parity_err;
   logic       overrun_set;
   logic [2:0] w1c;

   assign overrun_set = rx_push_req && rx_full && !rx_pop;
   assign w1c         = (wr_en && addr == A_STATUS) ? pwdata[6:4] : 3'b000;

   // A new set in the same cycle as a W1C clear wins.
   always_ff @(posedge pclk or negedge prstn) begin
      if (!prstn) begin
         overrun    <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         overrun    <= (overrun    & ~w1c[0]) | overrun_set;
         frame_err  <= (frame_err  & ~w1c[1]) | frame_set;
         parity_err <= (parity_err & ~w1c[2]) | parity_set;
      end
   end

   logic [7:0]  rx_lvl8;
   logic [7:0]  tx_lvl8;
   logic [31:0] status;

   assign rx_lvl8 = 8'(rx_level);
   assign tx_lvl8 = 8'(tx_level);
   assign status  = {8'h00, tx_lvl8, rx_lvl8, tx_busy, parity_err, frame_err, overrun,
                     rx_empty, rx_full, tx_empty, tx_full};

   assign uart_ti = ti_ie & tx_empty;
   assign uart_ri = ri_ie & (((rx_lvl8 >= rxthr) && (rxthr != 8'd0))
                             | overrun | frame_err | parity_err);

   always_comb begin
      prdata = 32'h0;
      if (psel) begin
         case (addr)
            A_DATA:   if (!rx_empty) prdata = {24'h0, rx_mem[rx_rd[AW-1:0]]};
            A_STATUS: prdata = status;
            A_CTRL:   prdata = {25'h0, ctrl};
            A_BAUD:   prdata = {16'h0, baud_div};
            A_RXTHR:  prdata = {24'h0, rxthr};
            default:  prdata = 32'h0;
         endcase
      end
   end

endmodule

// File: doc/uart_apb_fifo.md
# uart_apb_fifo

Parametrised APB UART for the e902 peripheral subsystem: one 8-bit serial channel with configurable TX/RX FIFOs, a programmable 16x-oversampling baud divider, optional parity, and level-based interrupts. It is the successor to the single-byte UART interface block. Firmware can queue multiple bytes and run at any baud rate without a rebuild.

## Interface
- FIFO_DEPTH, 16: entries per FIFO; power of two, 2..128.
- DIV_RESET, 26: reset value of BAUD.div; tick16 period is div+1 pclk (50 MHz, 115200 baud).
- pclk  input  1  APB clock; all logic runs on this clock.
- prstn  input  1  reset, asynchronous, active-low.
- paddr  input  32  byte address; only paddr[4:2] decoded.
- psel, penable, pwrite  input  1 each  APB controls.
- pwdata  input  32  write data.
- prdata  output  32  read data; valid in the access phase; 0 for unmapped addresses.
- pready  output  1  tied 1; no wait states.
- uart_rx  input  1  serial in, asynchronous.
- uart_tx  output  1  serial out; idle high.
- uart_ri  output  1  RX interrupt, level.
- uart_ti  output  1  TX interrupt, level.
- ext_uart_en  output  1  CTRL.ext_en; drives the external transceiver enable.

## Operation
- Register access: writes take effect on psel&penable&pwrite. Reads have side effects only on psel&penable&~pwrite.
- 0x00 DATA
  - Write: pushes pwdata[7:0] into TX FIFO; ignored if full.
  - Read: pops RX FIFO and returns {24'h0, byte}; returns 0 with no pop if empty.
- 0x04 STATUS (RO except W1C bits)
  - [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty.
  - [4] overrun, sticky W1C. [5] frame_err, sticky W1C. [6] parity_err, sticky W1C.
  - [7] tx_busy.
  - [15:8] rx_level, [23:16] tx_level.
- 0x08 CTRL, reset 0
  - [0] tx_en, [1] rx_en, [2] ti_ie, [3] ri_ie.
  - [4] par_en, [5] par_odd, [6] ext_en.
- 0x0C BAUD: [15:0] div, reset DIV_RESET.
- 0x10 RXTHR: [7:0] rx threshold, reset 1.
- Baud generator: counter counts div..0; tick16 is a one-cycle pulse at 0, then the counter reloads div. A BAUD write reloads the counter immediately.
- TX FSM: IDLE -> START -> DATA(8, LSB first) -> [PARITY if par_en] -> STOP -> IDLE.
  - Each bit lasts 16 tick16.
  - IDLE pops the FIFO when tx_en=1 and the FIFO is not empty.
  - Parity bit = ^data ^ par_odd.
  - tx_busy = state != IDLE.
- RX path: uart_rx passes through a 2-flop synchroniser, reset to 1.
- RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: a falling edge with rx_en=1 starts the frame; the counter aligns to sample at tick 8, and then every 16 ticks.
  - START: if the start sample is 1, the frame is aborted (glitch) and the FSM returns to IDLE with no flags.
  - STOP: stop sample 0 sets frame_err and drops the byte.
  - Parity mismatch sets parity_err; the byte is still pushed.
  - Push into a full RX FIFO drops the byte and sets overrun.
- Interrupts:
  - uart_ti = ti_ie & tx_empty.
  - uart_ri = ri_ie & ((rx_level >= RXTHR & RXTHR != 0) | overrun | frame_err | parity_err).
- Boundaries:
  - RX push and APB pop in the same cycle with the FIFO full: both succeed, no overrun.
  - TX pop and APB push in the same cycle with the FIFO empty: the push wins and the pop waits one cycle.
  - Clearing tx_en mid-frame: the current frame completes, then TX holds in IDLE.
  - Clearing rx_en mid-frame: the frame is abandoned and RX returns to IDLE.
  - FIFO pointers carry one extra wrap bit. Full = MSBs differ and the rest are equal.

## Timing
- All outputs reset: uart_tx=1, uart_ri=0, uart_ti=0, ext_uart_en=0, prdata=0, pready=1.
- Reset asserted mid-frame: uart_tx goes to 1 asynchronously, FIFOs empty, sticky flags 0.
- APB read data is combinational from registers in the access phase. The FIFO pop pointer advances at that clock edge.
- DATA write to first start-bit edge on uart_tx, with an idle, enabled TX: 2 pclk (push, then pop/load).
- One bit time on the wire is 16*(div+1) pclk. A frame is 10 bits, or 11 with par_en.
- The RX byte is visible in the FIFO one pclk after the stop-bit sample: rx_empty deasserts and uart_ri updates the same cycle.
- Status flags are registered. W1C clear and a new set in the same cycle: the set wins.

## Test plan
- Reset, then read all registers -> CTRL=0, BAUD=26, RXTHR=1, STATUS=0x0000_000A; uart_tx=1 throughout.
- BAUD=0, CTRL=0x01, write 0x55 -> uart_tx low for 16 pclk, then bits 1,0,1,0,1,0,1,0 at 16 pclk each, stop high; tx_empty and uart_ti (ti_ie=1) asserted afterwards.
- Loopback uart_tx->uart_rx, par_en=1, par_odd=1, write FIFO_DEPTH bytes 0x00..0x0F -> read back in order; tx_full seen after 16 writes; 17th write ignored.
- Drive 17 frames into RX with no reads (depth 16) -> rx_full, overrun=1, uart_ri=1 with ri_ie; 17th byte lost; W1C 0x10 clears overrun.
- RX stop bit forced 0 on byte 0xA5 -> frame_err=1, rx_empty stays 1. A 4-pclk low glitch on uart_rx -> no flags, no push.
- Assert prstn mid-TX-frame -> uart_tx=1 immediately; after release tx_level=0 and no residual bits are sent.
